// File: rtl/reg_bank_sequencer.sv
// Fills one register bank from the loader stream, then replays it N times to the MAC stream.
// Output appears 4 cycles after the last fill handshake; out_ready low stalls bank reads via a 2-entry skid FIFO.
module reg_bank_sequencer #(
    parameter int data_width = 8,
    parameter int bank_width = 64,
    parameter int addr_width = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            repeat_cnt,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] in_data,
    output logic                  bank_we,
    output logic [addr_width-1:0] bank_waddr,
    output logic [data_width-1:0] bank_wdata,
    output logic                  bank_re,
    output logic [addr_width-1:0] bank_raddr,
    input  logic [data_width-1:0] bank_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_data,
    output logic                  out_pass_end,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, FILL, FLUSH, DRAIN, DONE} state_t;

    localparam logic [addr_width-1:0] last_addr = addr_width'(bank_width - 1);

    state_t                  state, state_nxt;
    logic [3:0]              passes;
    logic [3:0]              pass_idx;
    logic [addr_width-1:0]   wr_cnt;
    logic                    rd_done;
    logic                    rd_inflight;
    logic                    rd_inflight_pe;
    logic                    rd_inflight_last;
    logic [data_width+1:0]   fifo_mem [2];
    logic                    fifo_wp;
    logic                    fifo_rp;
    logic [1:0]              fifo_cnt;
    logic [data_width+1:0]   head;
    logic                    in_fire;
    logic                    pop;
    logic                    frame_start;
    logic                    rd_last_pass;
    logic                    rd_pass_end;
    logic [2:0]              occupancy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = FILL;
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && wr_cnt == last_addr) state_nxt = FLUSH;
            end
            FLUSH: state_nxt = DRAIN;
            DRAIN: if (pop && head[0]) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_fire     = in_valid && in_ready;
    assign frame_start = (state == IDLE) && start;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    // Write path: registered so the last word lands in FLUSH, one cycle before the first read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_we    <= 1'b0;
            bank_waddr <= '0;
            bank_wdata <= '0;
            wr_cnt     <= '0;
            passes     <= 4'd0;
        end else begin
            bank_we <= in_fire;
            if (in_fire) begin
                bank_waddr <= wr_cnt;
                bank_wdata <= in_data;
                wr_cnt     <= (wr_cnt == last_addr) ? '0 : wr_cnt + 1'b1;
            end
            if (frame_start) begin
                wr_cnt <= '0;
                passes <= (repeat_cnt == 4'd0) ? 4'd1 : repeat_cnt;
            end
        end
    end

    // Reads are only launched when the FIFO is guaranteed a free slot for the returning word.
    assign pop          = out_valid && out_ready;
    assign occupancy    = 3'(fifo_cnt) + 3'(rd_inflight);
    assign bank_re      = (state == DRAIN) && !rd_done && (occupancy < 3'd2 + 3'(pop));
    assign rd_last_pass = (pass_idx == passes - 4'd1);
    assign rd_pass_end  = (bank_raddr == last_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_raddr       <= '0;
            pass_idx         <= 4'd0;
            rd_done          <= 1'b0;
            rd_inflight      <= 1'b0;
            rd_inflight_pe   <= 1'b0;
            rd_inflight_last <= 1'b0;
        end else begin
            rd_inflight      <= bank_re;
            rd_inflight_pe   <= bank_re && rd_pass_end;
            rd_inflight_last <= bank_re && rd_pass_end && rd_last_pass;
            if (frame_start) begin
                bank_raddr <= '0;
                pass_idx   <= 4'd0;
                rd_done    <= 1'b0;
            end else if (bank_re) begin
                if (rd_pass_end) begin
                    bank_raddr <= '0;
                    if (rd_last_pass) rd_done  <= 1'b1;
                    else              pass_idx <= pass_idx + 4'd1;
                end else begin
                    bank_raddr <= bank_raddr + 1'b1;
                end
            end
        end
    end

    // Entry layout: {data, pass_end, last}
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wp     <= 1'b0;
            fifo_rp     <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (rd_inflight) begin
                fifo_mem[fifo_wp] <= {bank_rdata, rd_inflight_pe, rd_inflight_last};
                fifo_wp           <= ~fifo_wp;
            end
            if (pop) fifo_rp <= ~fifo_rp;
            case ({rd_inflight, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign head         = fifo_mem[fifo_rp];
    assign out_valid    = (fifo_cnt != 2'd0);
    assign out_data     = out_valid ? head[data_width+1:2] : '0;
    assign out_pass_end = out_valid && head[1];
    assign out_last     = out_valid && head[0];

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Scoreboard bench: a frame-level model predicts bank writes and the replayed output stream.
module tb_reg_bank_sequencer;
    localparam int DW = 8;
    localparam int BW = 64;
    localparam int AW = 6;

    logic          clk;
    logic          reset;
    logic          start;
    logic [3:0]    repeat_cnt;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          bank_we;
    logic [AW-1:0] bank_waddr;
    logic [DW-1:0] bank_wdata;
    logic          bank_re;
    logic [AW-1:0] bank_raddr;
    logic [DW-1:0] bank_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_pass_end;
    logic          out_last;
    logic          busy;
    logic          done;

    reg_bank_sequencer #(.data_width(DW), .bank_width(BW), .addr_width(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .repeat_cnt(repeat_cnt),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bank_we(bank_we), .bank_waddr(bank_waddr), .bank_wdata(bank_wdata),
        .bank_re(bank_re), .bank_raddr(bank_raddr), .bank_rdata(bank_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pass_end(out_pass_end), .out_last(out_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct packed { logic [DW-1:0] data; logic pe; logic last; } out_t;

    wr_t           exp_wr[$];
    out_t          exp_out[$];
    logic [DW-1:0] src [BW];
    logic [DW-1:0] mem [BW];
    wr_t           w;
    out_t          o;
    logic [63:0]   outs;

    int  checks = 0, errors = 0, cyc = 0;
    int  fill_idx, rd_cnt, pop_cnt, total, m_passes, last_hs_cyc, done_cyc, frames_done, fd0;
    bit  m_busy, fill_active, seen_first, prev_stall, gap, rnd_rdy;
    logic [DW-1:0] prev_data;

    assign outs = 64'({in_ready, bank_we, bank_waddr, bank_wdata, bank_re, bank_raddr,
                       out_valid, out_data, out_pass_end, out_last, busy, done});

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register bank: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (bank_we) mem[bank_waddr] <= bank_wdata;
        if (bank_re) bank_rdata <= mem[bank_raddr];
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        in_valid  = fill_active && (!gap || cyc[0]);
        in_data   = (fill_idx < BW) ? src[fill_idx] : '0;
        out_ready = rnd_rdy ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", busy, m_busy);
            chk("done", done, cyc == done_cyc);
            chk("in_ready", in_ready, fill_active);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (bank_we) begin
                if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    w = exp_wr.pop_front();
                    chk("write_addr", bank_waddr, w.addr);
                    chk("write_data", bank_wdata, w.data);
                end
            end
            if (bank_re) begin
                chk("read_addr", bank_raddr, rd_cnt % BW);
                chk("read_count", rd_cnt < total, 1);
                chk("fifo_bound", (rd_cnt + 1 - pop_cnt - int'(out_valid && out_ready)) <= 2, 1);
                rd_cnt++;
            end
            if (out_valid && !seen_first) begin
                seen_first = 1;
                chk("first_out_latency", cyc, last_hs_cyc + 4);
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    o = exp_out.pop_front();
                    chk("out_word", {out_data, out_pass_end, out_last}, o);
                    if (o.last) begin
                        done_cyc = cyc + 1;
                        if (!rnd_rdy) chk("last_pop_latency", cyc, last_hs_cyc + 3 + BW * m_passes);
                    end
                end
                pop_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready) begin
                exp_wr.push_back(wr_t'{addr: AW'(fill_idx), data: src[fill_idx]});
                fill_idx++;
                if (fill_idx == BW) begin
                    fill_active = 0;
                    last_hs_cyc = cyc;
                    for (int p = 0; p < m_passes; p++)
                        for (int i = 0; i < BW; i++)
                            exp_out.push_back(out_t'{data: src[i], pe: (i == BW - 1),
                                                     last: (i == BW - 1) && (p == m_passes - 1)});
                end
            end
            if (start && !m_busy) begin
                m_busy      = 1;
                fill_active = 1;
                m_passes    = (repeat_cnt == 0) ? 1 : int'(repeat_cnt);
                total       = BW * m_passes;
                fill_idx    = 0;
                rd_cnt      = 0;
                pop_cnt     = 0;
                seen_first  = 0;
            end
            if (cyc == done_cyc) begin
                m_busy = 0;
                frames_done++;
            end
        end
    end

    task automatic launch(int rep, bit rnd_src);
        for (int i = 0; i < BW; i++) src[i] = rnd_src ? DW'($urandom) : DW'(i);
        fd0 = frames_done;
        @(posedge clk); #1;
        start = 1'b1;
        repeat_cnt = 4'(rep);
        @(posedge clk); #1;
        start = 1'b0;
        repeat_cnt = 4'd0;
    endtask

    task automatic wait_frame();
        int n = 0;
        while (frames_done == fd0 && n < 8000) begin @(posedge clk); n++; end
        chk("frame_complete", frames_done != fd0, 1);
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("out_queue_empty", exp_out.size(), 0);
    endtask

    task automatic wait_fill(int n);
        int k = 0;
        while (fill_idx < n && k < 2000) begin @(posedge clk); k++; end
        chk("wait_fill", fill_idx >= n, 1);
    endtask

    task automatic wait_pops(int n);
        int k = 0;
        while (pop_cnt < n && k < 4000) begin @(posedge clk); k++; end
        chk("wait_pops", pop_cnt >= n, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("reset_async_outputs", outs, 0);
        exp_wr.delete();
        exp_out.delete();
        fill_active = 0; m_busy = 0; done_cyc = -10; prev_stall = 0;
        fill_idx = 0; rd_cnt = 0; pop_cnt = 0; seen_first = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_held_outputs", outs, 0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; repeat_cnt = 4'd0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        gap = 0; rnd_rdy = 0; m_busy = 0; fill_active = 0; done_cyc = -10;
        fill_idx = 0; rd_cnt = 0; pop_cnt = 0; total = 0; m_passes = 1; last_hs_cyc = 0;
        frames_done = 0; fd0 = 0; seen_first = 0; prev_stall = 0; prev_data = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_state", outs, 0);
        reset = 1'b0;

        launch(1, 0); wait_frame();
        launch(3, 1); wait_frame();
        launch(0, 1); wait_frame();

        rnd_rdy = 1; launch(2, 1); wait_frame(); rnd_rdy = 0;
        gap = 1; launch(1, 1); wait_frame(); gap = 0;

        // A start while busy must not disturb the running frame's pass count.
        launch(2, 1);
        wait_pops(30);
        @(posedge clk); #1;
        start = 1'b1; repeat_cnt = 4'd5;
        @(posedge clk); #1;
        start = 1'b0; repeat_cnt = 4'd0;
        wait_frame();

        launch(1, 1); wait_fill(20); do_reset();
        launch(1, 0); wait_frame();

        launch(3, 1); wait_pops(100); do_reset();
        launch(2, 1); wait_frame();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_bank_sequencer.md
# reg_bank_sequencer

Controller that sequences one register bank in the matrix-multiplier datapath through fill and drain phases. It accepts one bank's worth of operands from an upstream valid/ready stream and writes them into the bank. It then replays the whole bank a programmable number of times to the downstream MAC stream, with full backpressure support. It sits between the operand loader and the register bank / MAC array and owns all bank write and read strobes.

## Interface
- data_width, 8, operand width in bits
- bank_width, 64, bank depth in words (≥2)
- addr_width, 6, bank address width; ≥ clog2(bank_width)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a frame; sampled only in IDLE
- repeat_cnt  in  4  number of drain passes, latched at start; 0 is treated as 1
- in_valid  in  1  upstream word valid
- in_ready  out  1  upstream word accepted when in_valid && in_ready
- in_data  in  data_width  upstream operand
- bank_we  out  1  bank write strobe
- bank_waddr  out  addr_width  bank write address
- bank_wdata  out  data_width  bank write data
- bank_re  out  1  bank read strobe
- bank_raddr  out  addr_width  bank read address
- bank_rdata  in  data_width  read data, valid the cycle after bank_re
- out_valid  out  1  downstream word valid
- out_ready  in  1  downstream accept
- out_data  out  data_width  downstream operand
- out_pass_end  out  1  qualifies out_data as the last word of a pass
- out_last  out  1  qualifies out_data as the last word of the frame
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame completion

## Operation
- States: IDLE, FILL, FLUSH, DRAIN, DONE.
- IDLE: in_ready=0. start=1 latches repeat_cnt (0→1) and moves to FILL. start is ignored in all other states.
- FILL: in_ready=1. Each handshake increments the write counter 0..bank_width-1. The handshake on word bank_width-1 moves to FLUSH.
- Writes are registered. A handshake in cycle t produces bank_we=1, bank_waddr=count, bank_wdata=in_data in cycle t+1.
- FLUSH: one cycle with in_ready=0. The final write is issued here. Next state is DRAIN.
- DRAIN: read address runs 0..bank_width-1, wraps to 0, and repeats for the latched pass count. Total reads = bank_width × passes.
- Output buffer: 2-entry FIFO feeding out_data/out_valid. bank_rdata is pushed the cycle after bank_re.
- bank_re is asserted when reads remain and (occupancy + reads_in_flight − pop_this_cycle) < 2. pop = out_valid && out_ready.
- Sustained throughput is 1 word/cycle while out_ready=1.
- out_pass_end and out_last travel through the FIFO with the data. They are set on read address bank_width-1, and out_last is set only on the final pass.
- A pop of the out_last word moves to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Bank contents are never written during DRAIN. Reads never target an address with a pending write.
- Reset (any time, including mid-FILL or mid-DRAIN): state=IDLE, counters=0, FIFO emptied, in-flight read discarded. All outputs go to 0 immediately (in_ready, bank_we, bank_waddr, bank_wdata, bank_re, bank_raddr, out_valid, out_data, out_pass_end, out_last, busy, done).

## Timing
- start in cycle s → FILL and in_ready=1 in s+1.
- Last fill handshake at t: bank_we (addr bank_width-1) at t+1 (FLUSH), first bank_re (addr 0) at t+2, rdata at t+3, out_valid=1 at t+4.
- With out_ready held high, words leave on consecutive cycles. Final pop at t+3+bank_width×passes; done at the next cycle, IDLE after that.
- out_ready low: out_valid and out_data hold stable. At most 2 buffered words plus 0 in-flight reads. bank_re stays low until a slot frees.
- in_valid low during FILL: no writes; the counter holds.
- busy rises the cycle after start and falls the cycle after done.

## Test plan
- Basic frame: start with repeat_cnt=1, feed 64 words 0x00..0x3F back-to-back, out_ready=1 → 64 writes with addr=data; out stream 0x00..0x3F on consecutive cycles; first out_valid 4 cycles after the last in handshake; out_pass_end and out_last on 0x3F; done a single pulse.
- Repeat passes: repeat_cnt=3 → 192 words, three copies of 0x00..0x3F; out_pass_end on words 63, 127 and 191; out_last only on word 191. repeat_cnt=0 gives exactly 64 words.
- Backpressure: random out_ready with 30% duty → no word dropped or duplicated; out_data stable while stalled; FIFO never exceeds 2 entries.
- Upstream gaps: in_valid toggling every other cycle → writes only on handshakes; addresses contiguous 0..63.
- Start while busy: pulse start mid-DRAIN with repeat_cnt=5 → ignored; the frame completes with the originally latched pass count.
- Reset mid-operation: assert reset at word 20 of FILL and again at word 100 of a 3-pass DRAIN → all outputs 0 asynchronously; after release, IDLE; a new frame runs correctly from address 0.
